dot_matrix_scanner: RTL and testbench

- Parametrised row-scanning driver for LED dot-matrix panels; successor to the fixed 8x8, 4-pattern display driver.
- Displays an arbitrary bitmap held in an internal double-buffered frame store instead of hard-wired glyphs.
- Adds per-row dwell time, anti-ghosting blanking, PWM brightness and tear-free frame swap.
- Sits between game logic (which writes rows of the frame) and the board's dot_row/dot_col pins.

---
 rtl/dot_matrix_pkg.sv | 25 ++
 rtl/dot_matrix_framebuf.sv | 57 +++++
 rtl/dot_matrix_scanner.sv | 134 +++++++++++++
 tb/tb_dot_matrix_scanner.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dot_matrix_pkg.sv
// rtl/dot_matrix_pkg.sv - shared types, defaults and pin-polarity helper for the dot-matrix scanner
//
// Contents:
//   DEF_ROWS, DEF_COLS : default panel geometry
//   scan_state_t       : scanner FSM states (idle, blank, drive)
//   row_level()        : maps "this row is selected" to the row pin level

package dot_matrix_pkg;

   localparam int DEF_ROWS = 8;
   localparam int DEF_COLS = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BLANK = 2'd1,
      ST_DRIVE = 2'd2
   } scan_state_t;

   // One bit of a one-hot row vector turned into its pin level.
   // An unselected row is always at the inactive level for the given polarity.
   function automatic logic row_level(input logic sel, input logic active_low);
      return sel ^ active_low;
   endfunction

endpackage

// File: rtl/dot_matrix_framebuf.sv
// rtl/dot_matrix_framebuf.sv - double-buffered ROWS x COLS frame store with swap
//
// Ports:
//   clk, reset       : clock, asynchronous active-high reset (clears both banks)
//   wr_en/wr_row/wr_data : one-row write into the back bank (out-of-range rows ignored)
//   swap             : toggles which bank is the front bank
//   rd_row/rd_data   : combinational read of the front bank
//   front_sel        : current front bank index

module dot_matrix_framebuf #(
   parameter int ROWS = 8,
   parameter int COLS = 8,
   parameter int RW   = $clog2(ROWS)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            wr_en,
   input  logic [RW-1:0]   wr_row,
   input  logic [COLS-1:0] wr_data,
   input  logic            swap,
   input  logic [RW-1:0]   rd_row,
   output logic [COLS-1:0] rd_data,
   output logic            front_sel
);

   logic [ROWS-1:0][COLS-1:0] bank0;
   logic [ROWS-1:0][COLS-1:0] bank1;
   logic                      wr_ok;

   assign wr_ok = wr_en && (int'(wr_row) < ROWS);

   // The back bank is chosen from the pre-swap front_sel, so a write in the
   // swap cycle lands in the bank that becomes the front on this edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bank0     <= '0;
         bank1     <= '0;
         front_sel <= 1'b0;
      end else begin
         if (wr_ok) begin
            if (front_sel)
               bank0[wr_row] <= wr_data;
            else
               bank1[wr_row] <= wr_data;
         end
         if (swap)
            front_sel <= ~front_sel;
      end
   end

   always_comb begin
      rd_data = '0;
      if (int'(rd_row) < ROWS)
         rd_data = front_sel ? bank1[rd_row] : bank0[rd_row];
   end

endmodule

// File: rtl/dot_matrix_scanner.sv
// rtl/dot_matrix_scanner.sv - row-scanning LED dot-matrix driver with PWM, blanking and tear-free swap
//
// Ports:
//   clk, reset   : clock, asynchronous active-high reset
//   enable       : scan enable; low blanks the panel and parks the scan at row 0
//   wr_en/wr_row/wr_data : write one row of the back buffer
//   swap_req     : request a front/back swap at the next frame boundary
//   brightness   : lit cycles per row drive phase, latched at each row start
//   dot_row      : row select pins (polarity from ROW_ACTIVE_LOW)
//   dot_col      : column drive pins, active-high
//   frame_start  : pulse as row 0 begins its blank phase
//   swap_done    : pulse when a swap takes effect

module dot_matrix_scanner
   import dot_matrix_pkg::*;
#(
   parameter int ROWS           = DEF_ROWS,
   parameter int COLS           = DEF_COLS,
   parameter int DWELL          = 16,
   parameter int BLANK          = 2,
   parameter int BR_W           = 4,
   parameter int ROW_ACTIVE_LOW = 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     enable,
   input  logic                     wr_en,
   input  logic [$clog2(ROWS)-1:0]  wr_row,
   input  logic [COLS-1:0]          wr_data,
   input  logic                     swap_req,
   input  logic [BR_W-1:0]          brightness,
   output logic [ROWS-1:0]          dot_row,
   output logic [COLS-1:0]          dot_col,
   output logic                     frame_start,
   output logic                     swap_done
);

   localparam int              RW       = $clog2(ROWS);
   localparam int              CW       = $clog2(DWELL);
   localparam logic            ACT_LOW  = (ROW_ACTIVE_LOW != 0);
   localparam logic [ROWS-1:0] ROW_OFF  = ACT_LOW ? {ROWS{1'b1}} : {ROWS{1'b0}};
   localparam logic [CW-1:0]   CNT_LAST = CW'(DWELL - 1);
   localparam logic [RW-1:0]   ROW_LAST = RW'(ROWS - 1);

   scan_state_t     state;
   logic [RW-1:0]   row;
   logic [CW-1:0]   cnt;
   logic [BR_W-1:0] br_lat;
   logic            pending;

   logic [COLS-1:0] front_row;
   logic            frame_edge;
   logic            swap_now;
   logic            drive_row;
   logic            lit;
   logic [ROWS-1:0] row_drive;

   dot_matrix_framebuf #(
      .ROWS (ROWS),
      .COLS (COLS),
      .RW   (RW)
   ) u_framebuf (
      .clk       (clk),
      .reset     (reset),
      .wr_en     (wr_en),
      .wr_row    (wr_row),
      .wr_data   (wr_data),
      .swap      (swap_now),
      .rd_row    (row),
      .rd_data   (front_row),
      .front_sel ()
   );

   always_comb begin
      frame_edge = enable && (state == ST_BLANK) && (row == '0) && (cnt == '0);
      // A pending swap goes in at the frame boundary, or straight away while
      // the panel is dark because enable is low.
      swap_now   = pending && (frame_edge || !enable);
      drive_row  = enable && (state == ST_DRIVE);
      // Drive phase offset compared against the on-time latched for this row.
      lit        = drive_row && ((int'(cnt) - BLANK) < int'(br_lat));
      for (int i = 0; i < ROWS; i++)
         row_drive[i] = row_level(drive_row && (int'(row) == i), ACT_LOW);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= ST_BLANK;
         row         <= '0;
         cnt         <= '0;
         br_lat      <= '0;
         pending     <= 1'b0;
         dot_row     <= ROW_OFF;
         dot_col     <= '0;
         frame_start <= 1'b0;
         swap_done   <= 1'b0;
      end else begin
         // Outputs are a registered view of this cycle's scan position.
         dot_row     <= row_drive;
         dot_col     <= lit ? front_row : '0;
         frame_start <= frame_edge;
         swap_done   <= swap_now;
         // New requests in the swap cycle stay pending for the next boundary.
         pending     <= swap_req || (pending && !swap_now);

         if (!enable) begin
            state <= ST_IDLE;
            row   <= '0;
            cnt   <= '0;
         end else begin
            case (state)
               ST_IDLE: begin
                  state <= ST_BLANK;
                  row   <= '0;
                  cnt   <= '0;
               end
               default: begin
                  if (state == ST_BLANK && cnt == '0)
                     br_lat <= brightness;
                  if (cnt == CNT_LAST) begin
                     cnt   <= '0;
                     state <= ST_BLANK;
                     row   <= (row == ROW_LAST) ? '0 : row + RW'(1);
                  end else begin
                     cnt   <= cnt + CW'(1);
                     state <= ((int'(cnt) + 1) < BLANK) ? ST_BLANK : ST_DRIVE;
                  end
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_dot_matrix_scanner.sv
// tb/tb_dot_matrix_scanner.sv - directed self-checking bench for dot_matrix_scanner

module tb_dot_matrix_scanner;

   logic       clk = 1'b0;
   logic       reset;
   logic       enable;
   logic       wr_en;
   logic [2:0] wr_row;
   logic [7:0] wr_data;
   logic       swap_req;
   logic [3:0] brightness;
   logic [7:0] dot_row;
   logic [7:0] dot_col;
   logic       frame_start;
   logic       swap_done;

   int checks   = 0;
   int failures = 0;
   int k        = 0;

   always #5 clk = ~clk;

   dot_matrix_scanner #(
      .ROWS           (8),
      .COLS           (8),
      .DWELL          (16),
      .BLANK          (2),
      .BR_W           (4),
      .ROW_ACTIVE_LOW (1)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .enable      (enable),
      .wr_en       (wr_en),
      .wr_row      (wr_row),
      .wr_data     (wr_data),
      .swap_req    (swap_req),
      .brightness  (brightness),
      .dot_row     (dot_row),
      .dot_col     (dot_col),
      .frame_start (frame_start),
      .swap_done   (swap_done)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
      k++;
   endtask

   task automatic advance_to(input int target);
      while (k < target) tick();
   endtask

   task automatic wait_frame(output logic sd);
      int n;
      n = 0;
      do begin
         tick();
         n++;
      end while (!frame_start && n < 400);
      check_eq("frame_wait", 32'(frame_start), 32'd1);
      sd = swap_done;
      k  = 0;
   endtask

   task automatic write_row(input logic [2:0] r, input logic [7:0] d);
      wr_en   = 1'b1;
      wr_row  = r;
      wr_data = d;
      tick();
      wr_en   = 1'b0;
   endtask

   task automatic pulse_swap();
      swap_req = 1'b1;
      tick();
      swap_req = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic       sd;
      logic [7:0] onehot;
      logic [7:0] exp_row;
      int         first_fs;
      int         second_fs;
      int         fs_cnt;
      int         bad_col;
      int         bad_row;
      int         sd_cnt;
      int         p;

      reset      = 1'b1;
      enable     = 1'b1;
      wr_en      = 1'b0;
      wr_row     = '0;
      wr_data    = '0;
      swap_req   = 1'b0;
      brightness = 4'd15;

      repeat (3) @(negedge clk);
      check_eq("reset_dot_row", 32'(dot_row), 32'hFF);
      check_eq("reset_dot_col", 32'(dot_col), 32'h00);
      check_eq("reset_frame_start", 32'(frame_start), 32'd0);
      check_eq("reset_swap_done", 32'(swap_done), 32'd0);

      // Idle frame store: columns dark, rows scan, frame_start every 128 cycles.
      reset     = 1'b0;
      k         = 0;
      first_fs  = -1;
      second_fs = -1;
      fs_cnt    = 0;
      bad_col   = 0;
      bad_row   = 0;
      for (int i = 1; i <= 257; i++) begin
         tick();
         if (frame_start) begin
            if (first_fs < 0) first_fs = i;
            else if (second_fs < 0) second_fs = i;
            fs_cnt++;
         end
         if (dot_col != 8'h00) bad_col++;
         p       = i - 1;
         onehot  = 8'h01 << ((p / 16) % 8);
         exp_row = ((p % 16) < 2) ? 8'hFF : ~onehot;
         if (dot_row != exp_row) bad_row++;
      end
      check_eq("first_frame_start", 32'(first_fs), 32'd1);
      check_eq("second_frame_start", 32'(second_fs), 32'd129);
      check_eq("frame_start_count", 32'(fs_cnt), 32'd3);
      check_eq("idle_cols_dark", 32'(bad_col), 32'd0);
      check_eq("idle_row_scan", 32'(bad_row), 32'd0);
      k = 0;

      // Row 3 = A5 after a swap, full brightness.
      write_row(3'd3, 8'hA5);
      pulse_swap();
      advance_to(60);
      check_eq("no_early_swap", 32'(swap_done), 32'd0);
      wait_frame(sd);
      check_eq("swap_with_frame", 32'(sd), 32'd1);
      advance_to(49);
      check_eq("row3_blank_col", 32'(dot_col), 32'h00);
      check_eq("row3_blank_row", 32'(dot_row), 32'hFF);
      for (int c = 2; c <= 15; c++) begin
         advance_to(48 + c);
         check_eq("row3_drive_row", 32'(dot_row), 32'hF7);
         check_eq("row3_drive_col", 32'(dot_col), 32'hA5);
      end
      advance_to(64);
      check_eq("row4_blank_col", 32'(dot_col), 32'h00);

      // Brightness 4 on a full row, then raised to 8 mid-row.
      write_row(3'd1, 8'hFF);
      write_row(3'd2, 8'hFF);
      write_row(3'd3, 8'hA5);
      brightness = 4'd4;
      pulse_swap();
      wait_frame(sd);
      check_eq("swap2_done", 32'(sd), 32'd1);
      for (int c = 0; c <= 15; c++) begin
         advance_to(16 + c);
         check_eq("pwm4_row1", 32'(dot_col), ((c >= 2) && (c < 6)) ? 32'hFF : 32'h00);
         if (c == 4) brightness = 4'd8;
      end
      advance_to(32 + 9);
      check_eq("pwm8_row2_on", 32'(dot_col), 32'hFF);
      advance_to(32 + 10);
      check_eq("pwm8_row2_off", 32'(dot_col), 32'h00);

      // Back-buffer write plus three swap requests: one swap at the boundary.
      write_row(3'd3, 8'h3C);
      pulse_swap();
      tick();
      pulse_swap();
      tick();
      pulse_swap();
      advance_to(53);
      check_eq("old_frame_kept", 32'(dot_col), 32'hA5);
      wait_frame(sd);
      check_eq("merged_swap_done", 32'(sd), 32'd1);
      sd_cnt = 0;
      for (int i = 1; i <= 128; i++) begin
         tick();
         if (swap_done) sd_cnt++;
         if (k == 53) check_eq("new_frame_shown", 32'(dot_col), 32'h3C);
      end
      check_eq("single_swap", 32'(sd_cnt), 32'd0);
      check_eq("frame_period", 32'(frame_start), 32'd1);
      k = 0;

      // Drop enable mid-row 5 for 3 cycles with a swap pending.
      pulse_swap();
      advance_to(86);
      check_eq("row5_drive", 32'(dot_row), 32'hDF);
      enable = 1'b0;
      sd_cnt = 0;
      tick();
      check_eq("disable_dark_row", 32'(dot_row), 32'hFF);
      check_eq("disable_dark_col", 32'(dot_col), 32'h00);
      if (swap_done) sd_cnt++;
      tick();
      if (swap_done) sd_cnt++;
      tick();
      if (swap_done) sd_cnt++;
      check_eq("idle_dark_row", 32'(dot_row), 32'hFF);
      enable = 1'b1;
      tick();
      if (swap_done) sd_cnt++;
      check_eq("idle_exit_no_fs", 32'(frame_start), 32'd0);
      tick();
      if (swap_done) sd_cnt++;
      check_eq("restart_frame", 32'(frame_start), 32'd1);
      check_eq("disable_swap_once", 32'(sd_cnt), 32'd1);
      k = 0;
      advance_to(18);
      check_eq("restart_row1", 32'(dot_row), 32'hFD);

      // Reset in the middle of a lit drive phase.
      advance_to(20);
      check_eq("pre_reset_drive", 32'(dot_col), 32'hFF);
      #2 reset = 1'b1;
      #1;
      check_eq("async_reset_row", 32'(dot_row), 32'hFF);
      check_eq("async_reset_col", 32'(dot_col), 32'h00);
      @(negedge clk);
      reset      = 1'b0;
      brightness = 4'd15;
      bad_col    = 0;
      for (int i = 1; i <= 256; i++) begin
         tick();
         if (i == 1) check_eq("post_reset_fs", 32'(frame_start), 32'd1);
         if (dot_col != 8'h00) bad_col++;
         if (i == 10) swap_req = 1'b1;
         if (i == 11) swap_req = 1'b0;
         if (i == 129) check_eq("post_reset_swap", 32'(swap_done), 32'd1);
      end
      check_eq("store_cleared", 32'(bad_col), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
